// File: rtl/space_impact_pkg.sv
// rtl/space_impact_pkg.sv - shared LED matrix geometry, types and scan state encoding
// Purpose: common definitions for the display path of the game.
// Ports: none (package).
// Config macro used by the display path: BRIGHTNESS_PWM_EN.
package space_impact_pkg;

  localparam int MATRIX_COLS = 24;
  localparam int MATRIX_ROWS = 16;
  localparam int ROW_IDX_W   = 4;

  typedef logic [ROW_IDX_W-1:0]   rowIdx_t;
  typedef logic [MATRIX_COLS-1:0] rowData_t;

  typedef enum logic {
    BLANK = 1'b0,
    DRIVE = 1'b1
  } scanState_t;

  function automatic int maxInt(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/led_matrix_scanner_scan_timer.sv
// rtl/led_matrix_scanner_scan_timer.sv - row phase counter and BLANK/DRIVE scan FSM
// Purpose: sequences BLANK (BLANK_CYC) then DRIVE (DWELL_CYC) for each row, rows 0..ROWS-1 wrapping.
// Ports:
//   clk50      in   clock, posedge
//   reset      in   synchronous active-high reset
//   state      out  current scan state
//   rowIdx     out  row currently blanked/driven
//   phase      out  cycle index within the current state
//   driveFirst out  last BLANK cycle: the next cycle is the first DRIVE cycle of rowIdx
//   rowEnd     out  last DRIVE cycle of rowIdx
//   frameEnd   out  last DRIVE cycle of the last row
module scan_timer
  import space_impact_pkg::*;
#(
  parameter int ROWS      = MATRIX_ROWS,
  parameter int DWELL_CYC = 3125,
  parameter int BLANK_CYC = 50,
  localparam int CNT_W    = maxInt($clog2(maxInt(DWELL_CYC, BLANK_CYC)), 1)
) (
  input  logic             clk50,
  input  logic             reset,
  output scanState_t       state,
  output rowIdx_t          rowIdx,
  output logic [CNT_W-1:0] phase,
  output logic             driveFirst,
  output logic             rowEnd,
  output logic             frameEnd
);

  localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYC - 1);
  localparam logic [CNT_W-1:0] DRIVE_LAST = CNT_W'(DWELL_CYC - 1);
  localparam rowIdx_t          LAST_ROW   = rowIdx_t'(ROWS - 1);

  scanState_t       nextState;
  rowIdx_t          nextRow;
  logic [CNT_W-1:0] nextPhase;

  always_ff @(posedge clk50) begin
    if (reset) begin
      state  <= BLANK;
      rowIdx <= '0;
      phase  <= '0;
    end else begin
      state  <= nextState;
      rowIdx <= nextRow;
      phase  <= nextPhase;
    end
  end

  always_comb begin
    nextState = state;
    nextRow   = rowIdx;
    nextPhase = phase + 1'b1;
    case (state)
      BLANK: begin
        if (phase == BLANK_LAST) begin
          nextState = DRIVE;
          nextPhase = '0;
        end
      end
      DRIVE: begin
        if (phase == DRIVE_LAST) begin
          nextState = BLANK;
          nextPhase = '0;
          nextRow   = (rowIdx == LAST_ROW) ? '0 : rowIdx + 1'b1;
        end
      end
      default: begin
        nextState = BLANK;
        nextPhase = '0;
      end
    endcase
  end

  always_comb begin
    driveFirst = (state == BLANK) && (phase == BLANK_LAST);
    rowEnd     = (state == DRIVE) && (phase == DRIVE_LAST);
    frameEnd   = rowEnd && (rowIdx == LAST_ROW);
  end

endmodule

// File: rtl/led_matrix_scanner.sv
// rtl/led_matrix_scanner.sv - double-buffered frame store and row-multiplexed LED matrix driver
// Purpose: game thread writes rows into the back bank and requests a swap; the front bank is scanned out.
// Optional feature macro: BRIGHTNESS_PWM_EN (column PWM within each row dwell).
// Ports:
//   clk50       in   clock, posedge
//   reset       in   synchronous active-high reset
//   wr_en       in   write wr_data into back bank row wr_row
//   wr_row      in   target row (rows >= ROWS ignored)
//   wr_data     in   row pixels, bit c = column c
//   swap_req    in   request bank exchange at next frame boundary
//   brightness  in   PWM level 0..7 (ignored unless BRIGHTNESS_PWM_EN)
//   swap_ack    out  1-cycle pulse, first cycle with the exchanged banks
//   frame_start out  1-cycle pulse on the first DRIVE cycle of row 0
//   row16       out  one-hot row select, 0 during blanking
//   col24       out  column data of the selected row
module led_matrix_scanner
  import space_impact_pkg::*;
#(
  parameter int COLS      = MATRIX_COLS,
  parameter int ROWS      = MATRIX_ROWS,
  parameter int DWELL_CYC = 3125,
  parameter int BLANK_CYC = 50
) (
  input  logic                 clk50,
  input  logic                 reset,
  input  logic                 wr_en,
  input  logic [ROW_IDX_W-1:0] wr_row,
  input  logic [COLS-1:0]      wr_data,
  input  logic                 swap_req,
  input  logic [2:0]           brightness,
  output logic                 swap_ack,
  output logic                 frame_start,
  output logic [ROWS-1:0]      row16,
  output logic [COLS-1:0]      col24
);

  localparam int CNT_W = maxInt($clog2(maxInt(DWELL_CYC, BLANK_CYC)), 1);

  logic [COLS-1:0]  bank [2][ROWS];
  logic             frontSel;
  logic             backSel;
  logic             swapPending;
  logic             wrOk;

  scanState_t       state;
  rowIdx_t          rowIdx;
  logic [CNT_W-1:0] phase;
  logic             driveFirst;
  logic             rowEnd;
  logic             frameEnd;

  scan_timer #(
    .ROWS      (ROWS),
    .DWELL_CYC (DWELL_CYC),
    .BLANK_CYC (BLANK_CYC)
  ) u_scan_timer (
    .clk50      (clk50),
    .reset      (reset),
    .state      (state),
    .rowIdx     (rowIdx),
    .phase      (phase),
    .driveFirst (driveFirst),
    .rowEnd     (rowEnd),
    .frameEnd   (frameEnd)
  );

  assign backSel = ~frontSel;
  assign wrOk    = int'(wr_row) < ROWS;

`ifdef BRIGHTNESS_PWM_EN
  // Number of lit cycles at the start of the dwell for the sampled brightness.
  logic [CNT_W:0] litCalc;
  logic [CNT_W:0] litLen;
  assign litCalc = (CNT_W+1)'(((int'(brightness) + 1) * DWELL_CYC) / 8);
`else
  logic unusedSigs;
  assign unusedSigs = ^{brightness, phase, state};
`endif

  always_ff @(posedge clk50) begin
    if (reset) begin
      for (int b = 0; b < 2; b++) begin
        for (int r = 0; r < ROWS; r++) begin
          bank[b][r] <= '0;
        end
      end
      frontSel    <= 1'b0;
      swapPending <= 1'b0;
      swap_ack    <= 1'b0;
      frame_start <= 1'b0;
      row16       <= '0;
      col24       <= '0;
`ifdef BRIGHTNESS_PWM_EN
      litLen      <= '0;
`endif
    end else begin
      // A write on the swap cycle lands in the old back bank, which becomes the new front.
      if (wr_en && wrOk) begin
        bank[backSel][wr_row] <= wr_data;
      end

      swap_ack    <= 1'b0;
      frame_start <= 1'b0;
      // A request arriving on the frame-end cycle is served by this swap, not queued.
      if (frameEnd && (swapPending || swap_req)) begin
        frontSel    <= ~frontSel;
        swapPending <= 1'b0;
        swap_ack    <= 1'b1;
      end else if (swap_req) begin
        swapPending <= 1'b1;
      end

      // Row data is latched once on DRIVE entry and held, so mid-row writes never reach the pins.
      if (driveFirst) begin
        row16       <= ROWS'(1) << rowIdx;
        frame_start <= (rowIdx == '0);
`ifdef BRIGHTNESS_PWM_EN
        litLen      <= litCalc;
        col24       <= (litCalc == '0) ? '0 : bank[frontSel][rowIdx];
`else
        col24       <= bank[frontSel][rowIdx];
`endif
      end else if (rowEnd) begin
        row16 <= '0;
        col24 <= '0;
      end
`ifdef BRIGHTNESS_PWM_EN
      else if ((state == DRIVE) && (((CNT_W+1)'(phase) + (CNT_W+1)'(1)) >= litLen)) begin
        col24 <= '0;
      end
`endif
    end
  end

endmodule
